// File: rtl/issue_tile_scheduler.sv
// rtl/issue_tile_scheduler.sv - walks a padded plane in alloc_len-pixel raster chunks, re-arming one issue unit per chunk
module issue_tile_scheduler #(
  parameter int ISSUE_RST_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [7:0]  image_dim,
  input  logic [1:0]  image_padding,
  input  logic [11:0] alloc_len,
  output logic        busy,
  output logic        cfg_err,
  output logic        chunk_done,
  output logic        all_done,
  output logic [15:0] chunk_idx,
  output logic        issue_rst,
  output logic [7:0]  issue_x_min,
  output logic [7:0]  issue_x_max,
  output logic [7:0]  issue_x_start,
  output logic [7:0]  issue_x_end,
  output logic [7:0]  issue_y_min,
  output logic [7:0]  issue_y_max,
  input  logic        issue_done,
  output logic        issue_block,
  input  logic        sink_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_NORM,
    S_ARM,
    S_RUN,
    S_ADV,
    S_FIN
  } state_t;

  localparam int ARM_W = (ISSUE_RST_CYCLES > 1) ? $clog2(ISSUE_RST_CYCLES) : 1;
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(ISSUE_RST_CYCLES - 1);

  state_t            state;
  logic [8:0]        p;
  logic [7:0]        pm1;
  logic [11:0]       alen;
  logic [7:0]        cur_x;
  logic [7:0]        cur_y;
  logic [12:0]       end_x;
  logic [7:0]        end_y;
  logic [ARM_W-1:0]  arm_cnt;

  logic [8:0]        p_req;
  logic              wrap_hit;
  logic              clamp_hit;
  logic [7:0]        fin_x;
  logic [7:0]        fin_y;
  logic [8:0]        next_x;

  // P-1 taken modulo 256 so that P=256 still yields 255
  assign pm1       = p[7:0] - 8'd1;
  assign p_req     = {1'b0, image_dim} + {6'b0, image_padding, 1'b0};
  assign wrap_hit  = (end_x >= {4'b0, p});
  assign clamp_hit = wrap_hit && (({1'b0, end_y} + 9'd1) >= p);
  assign fin_x     = clamp_hit ? pm1 : end_x[7:0];
  assign fin_y     = clamp_hit ? pm1 : end_y;
  assign next_x    = {1'b0, end_x[7:0]} + 9'd1;

  assign issue_x_min = 8'd0;
  // back-pressure must reach the issue unit in the same cycle
  assign issue_block = (state != S_RUN) || !sink_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      p             <= 9'd0;
      alen          <= 12'd1;
      cur_x         <= 8'd0;
      cur_y         <= 8'd0;
      end_x         <= 13'd0;
      end_y         <= 8'd0;
      arm_cnt       <= '0;
      busy          <= 1'b0;
      cfg_err       <= 1'b0;
      chunk_done    <= 1'b0;
      all_done      <= 1'b0;
      chunk_idx     <= 16'd0;
      issue_rst     <= 1'b1;
      issue_x_max   <= 8'd0;
      issue_x_start <= 8'd0;
      issue_x_end   <= 8'd0;
      issue_y_min   <= 8'd0;
      issue_y_max   <= 8'd0;
    end else begin
      cfg_err    <= 1'b0;
      chunk_done <= 1'b0;
      all_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (p_req > 9'd256) begin
              cfg_err <= 1'b1;
            end else begin
              p         <= p_req;
              alen      <= (alloc_len == 12'd0) ? 12'd1 : alloc_len;
              cur_x     <= 8'd0;
              cur_y     <= 8'd0;
              chunk_idx <= 16'd0;
              busy      <= 1'b1;
              state     <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          end_x <= {5'b0, cur_x} + {1'b0, alen} - 13'd1;
          end_y <= cur_y;
          state <= S_NORM;
        end
        S_NORM: begin
          // one row wrap per cycle; running past the last row clamps to the final pixel
          if (clamp_hit || !wrap_hit) begin
            end_x         <= {5'b0, fin_x};
            end_y         <= fin_y;
            issue_x_start <= cur_x;
            issue_x_end   <= fin_x;
            issue_y_min   <= cur_y;
            issue_y_max   <= fin_y;
            issue_x_max   <= (fin_y == cur_y) ? fin_x : pm1;
            arm_cnt       <= '0;
            state         <= S_ARM;
          end else begin
            end_x <= end_x - {4'b0, p};
            end_y <= end_y + 8'd1;
          end
        end
        S_ARM: begin
          if (arm_cnt == ARM_LAST) begin
            issue_rst <= 1'b0;
            state     <= S_RUN;
          end else begin
            arm_cnt <= arm_cnt + ARM_W'(1);
          end
        end
        S_RUN: begin
          if (issue_done) begin
            chunk_done <= 1'b1;
            issue_rst  <= 1'b1;
            state      <= ((end_x[7:0] == pm1) && (end_y == pm1)) ? S_FIN : S_ADV;
          end
        end
        S_ADV: begin
          if (next_x == p) begin
            cur_x <= 8'd0;
            cur_y <= end_y + 8'd1;
          end else begin
            cur_x <= next_x[7:0];
            cur_y <= end_y;
          end
          chunk_idx <= chunk_idx + 16'd1;
          state     <= S_LOAD;
        end
        S_FIN: begin
          all_done <= 1'b1;
          busy     <= 1'b0;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_issue_tile_scheduler.sv
// tb/tb_issue_tile_scheduler.sv - randomized chunk sequencing checked against a linear-pixel model
module tb_issue_tile_scheduler;

  localparam int N_ARM = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  image_dim;
  logic [1:0]  image_padding;
  logic [11:0] alloc_len;
  logic        busy;
  logic        cfg_err;
  logic        chunk_done;
  logic        all_done;
  logic [15:0] chunk_idx;
  logic        issue_rst;
  logic [7:0]  issue_x_min;
  logic [7:0]  issue_x_max;
  logic [7:0]  issue_x_start;
  logic [7:0]  issue_x_end;
  logic [7:0]  issue_y_min;
  logic [7:0]  issue_y_max;
  logic        issue_done;
  logic        issue_block;
  logic        sink_ready;

  issue_tile_scheduler #(.ISSUE_RST_CYCLES(N_ARM)) dut (
    .clk(clk), .rst(rst), .start(start), .image_dim(image_dim),
    .image_padding(image_padding), .alloc_len(alloc_len), .busy(busy),
    .cfg_err(cfg_err), .chunk_done(chunk_done), .all_done(all_done),
    .chunk_idx(chunk_idx), .issue_rst(issue_rst), .issue_x_min(issue_x_min),
    .issue_x_max(issue_x_max), .issue_x_start(issue_x_start),
    .issue_x_end(issue_x_end), .issue_y_min(issue_y_min),
    .issue_y_max(issue_y_max), .issue_done(issue_done),
    .issue_block(issue_block), .sink_ready(sink_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cx; int cy; int ex; int ey; int xmax; int wraps;
  } chunk_t;

  chunk_t plan_q[$];

  int   total = 0;
  int   bad = 0;
  logic chk_en = 1'b0;

  logic e_busy, e_cfg, e_cdone, e_adone, e_rst, e_run;
  int   e_idx, e_xmax, e_xs, e_xe, e_ymin, e_ymax;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // chunks expressed as linear pixel ranges [s, min(s+len-1, P*P-1)]
  task automatic make_plan(input int p, input int len);
    int     s;
    int     a;
    int     e;
    int     tot;
    chunk_t ch;
    s   = 0;
    a   = (len == 0) ? 1 : len;
    tot = p * p;
    plan_q.delete();
    forever begin
      e = s + a - 1;
      ch.cx = s % p;
      ch.cy = s / p;
      if (e > tot - 1) begin
        e = tot - 1;
        ch.wraps = p - 1 - ch.cy;
      end else begin
        ch.wraps = (ch.cx + a - 1) / p;
      end
      ch.ex   = e % p;
      ch.ey   = e / p;
      ch.xmax = (ch.ey == ch.cy) ? ch.ex : p - 1;
      plan_q.push_back(ch);
      if (e == tot - 1) break;
      s = e + 1;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, e_busy);
      chk("cfg_err", cfg_err, e_cfg);
      chk("chunk_done", chunk_done, e_cdone);
      chk("all_done", all_done, e_adone);
      chk("chunk_idx", chunk_idx, e_idx);
      chk("issue_rst", issue_rst, e_rst);
      chk("issue_block", issue_block, e_run ? !sink_ready : 1'b1);
      chk("x_min", issue_x_min, 0);
      chk("x_max", issue_x_max, e_xmax);
      chk("x_start", issue_x_start, e_xs);
      chk("x_end", issue_x_end, e_xe);
      chk("y_min", issue_y_min, e_ymin);
      chk("y_max", issue_y_max, e_ymax);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_reset_exp();
    e_busy = 0; e_cfg = 0; e_cdone = 0; e_adone = 0; e_rst = 1; e_run = 0;
    e_idx = 0; e_xmax = 0; e_xs = 0; e_xe = 0; e_ymin = 0; e_ymax = 0;
  endtask

  task automatic run_job(input int dim, input int pad, input int len, input int abort_c);
    int nrun;
    make_plan(dim + 2 * pad, len);
    image_dim = 8'(dim); image_padding = 2'(pad); alloc_len = 12'(len); start = 1;
    cyc();
    start = 0; e_busy = 1; e_idx = 0;
    for (int c = 0; c < plan_q.size(); c++) begin
      repeat (1 + plan_q[c].wraps) cyc();
      cyc();
      e_xs = plan_q[c].cx; e_xe = plan_q[c].ex; e_ymin = plan_q[c].cy;
      e_ymax = plan_q[c].ey; e_xmax = plan_q[c].xmax;
      repeat (N_ARM - 1) cyc();
      cyc();
      e_rst = 0; e_run = 1;
      nrun = $urandom_range(1, 6);
      for (int i = 0; i < nrun; i++) begin
        sink_ready = 1'($urandom_range(0, 1));
        if (i == 0 && c == 0) begin
          start = 1; image_dim = 8'($urandom); alloc_len = 12'($urandom);
        end
        if (c == abort_c && i == 1) begin
          rst = 1; issue_done = 1;
          cyc();
          rst = 0; issue_done = 0;
          set_reset_exp();
          cyc();
          return;
        end
        cyc();
        start = 0;
      end
      issue_done = 1; sink_ready = 1'($urandom_range(0, 1));
      cyc();
      issue_done = 0; e_rst = 1; e_run = 0; e_cdone = 1;
      cyc();
      e_cdone = 0;
      if (c == plan_q.size() - 1) begin
        e_adone = 1; e_busy = 0;
        cyc();
        e_adone = 0;
      end else begin
        e_idx = c + 1;
      end
    end
  endtask

  initial begin
    rst = 1; start = 0; issue_done = 0; sink_ready = 1;
    image_dim = 0; image_padding = 0; alloc_len = 0;
    set_reset_exp();

    make_plan(6, 36);
    chk("pin36_n", plan_q.size(), 1);
    chk("pin36_end", plan_q[0].ex * 16 + plan_q[0].ey, 5 * 16 + 5);
    chk("pin36_xmax", plan_q[0].xmax, 5);
    make_plan(6, 10);
    chk("pin10_n", plan_q.size(), 4);
    chk("pin10_c0", plan_q[0].ex * 16 + plan_q[0].ey, 3 * 16 + 1);
    chk("pin10_c1", plan_q[1].cx * 4096 + plan_q[1].cy * 256 + plan_q[1].ex * 16 + plan_q[1].ey,
        4 * 4096 + 1 * 256 + 1 * 16 + 3);
    chk("pin10_c2", plan_q[2].cx * 4096 + plan_q[2].cy * 256 + plan_q[2].ex * 16 + plan_q[2].ey,
        2 * 4096 + 3 * 256 + 5 * 16 + 4);
    chk("pin10_c3", plan_q[3].cx * 4096 + plan_q[3].cy * 256 + plan_q[3].ex * 16 + plan_q[3].ey,
        0 * 4096 + 5 * 256 + 5 * 16 + 5);
    make_plan(6, 4);
    chk("pin4_n", plan_q.size(), 9);
    chk("pin4_x0", plan_q[0].xmax, 3);
    chk("pin4_x1", plan_q[1].xmax, 5);
    chk("pin4_c1", plan_q[1].ex * 16 + plan_q[1].ey, 1 * 16 + 1);

    repeat (2) cyc();
    chk_en = 1;
    cyc();
    rst = 0;
    cyc();

    run_job(4, 1, 36, -1);
    run_job(4, 1, 10, -1);
    run_job(4, 1, 4, -1);

    image_dim = 255; image_padding = 1; alloc_len = 10; start = 1;
    cyc();
    start = 0; e_cfg = 1;
    cyc();
    e_cfg = 0;
    cyc();

    run_job(4, 1, 10, 2);
    run_job(1, 0, 0, -1);
    run_job(2, 0, 4095, -1);
    run_job(250, 3, 4095, -1);
    for (int j = 0; j < 8; j++) begin
      run_job($urandom_range(1, 12), $urandom_range(0, 3), $urandom_range(0, 50), -1);
      repeat ($urandom_range(0, 3)) cyc();
    end

    cyc();
    chk_en = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
